// File: rtl/apb_periph_arbiter.sv
// Two-requester round-robin APB arbiter onto one shared peripheral bus.
// Stalled ACCESS phases are cut off by a timeout and completed with an error.
module apb_periph_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic [APB_ADDR_WIDTH-1:0] s0_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s0_pwdata,
  input  logic                      s0_pwrite,
  input  logic                      s0_psel,
  input  logic                      s0_penable,
  output logic [APB_DATA_WIDTH-1:0] s0_prdata,
  output logic                      s0_pready,
  output logic                      s0_pslverr,

  input  logic [APB_ADDR_WIDTH-1:0] s1_paddr,
  input  logic [APB_DATA_WIDTH-1:0] s1_pwdata,
  input  logic                      s1_pwrite,
  input  logic                      s1_psel,
  input  logic                      s1_penable,
  output logic [APB_DATA_WIDTH-1:0] s1_prdata,
  output logic                      s1_pready,
  output logic                      s1_pslverr,

  output logic [APB_ADDR_WIDTH-1:0] m_paddr,
  output logic [APB_DATA_WIDTH-1:0] m_pwdata,
  output logic                      m_pwrite,
  output logic                      m_psel,
  output logic                      m_penable,
  input  logic [APB_DATA_WIDTH-1:0] m_prdata,
  input  logic                      m_pready,
  input  logic                      m_pslverr,

  output logic [7:0]                timeout_cnt_o,
  output logic                      busy_o
);

  // state  | meaning
  // IDLE   | master bus idle; arbitrate between requesters
  // SETUP  | APB setup phase driven on the master bus
  // ACCESS | APB access phase; wait for m_pready or the timeout
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                    state;
  logic                      grant;
  logic [TW-1:0]             to_cnt;
  logic                      pick;
  logic                      to_fire;
  logic                      xfer_done;
  logic [APB_DATA_WIDTH-1:0] resp_data;
  logic                      resp_err;
  logic                      unused_penable;

  // The requester side phase is implied by psel; penable carries no extra information here.
  assign unused_penable = s0_penable | s1_penable;

  // grant doubles as last-grant: on a tie the other requester wins.
  assign pick      = (s0_psel && s1_psel) ? ~grant : s1_psel;
  assign to_fire   = (TIMEOUT_CYCLES > 0) && (state == ACCESS) && !m_pready && (to_cnt == TO_LAST);
  assign xfer_done = (state == ACCESS) && (m_pready || to_fire);
  assign resp_data = m_pready ? m_prdata : '0;
  assign resp_err  = m_pready ? m_pslverr : 1'b1;
  assign busy_o    = (state != IDLE);

  // A requester that dropped psel mid-transfer gets no response; it is discarded.
  assign s0_pready  = xfer_done && !grant && s0_psel;
  assign s0_prdata  = s0_pready ? resp_data : '0;
  assign s0_pslverr = s0_pready && resp_err;
  assign s1_pready  = xfer_done && grant && s1_psel;
  assign s1_prdata  = s1_pready ? resp_data : '0;
  assign s1_pslverr = s1_pready && resp_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      grant         <= 1'b1;
      to_cnt        <= '0;
      timeout_cnt_o <= '0;
      m_paddr       <= '0;
      m_pwdata      <= '0;
      m_pwrite      <= 1'b0;
      m_psel        <= 1'b0;
      m_penable     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_psel || s1_psel) begin
            grant    <= pick;
            m_paddr  <= pick ? s1_paddr  : s0_paddr;
            m_pwdata <= pick ? s1_pwdata : s0_pwdata;
            m_pwrite <= pick ? s1_pwrite : s0_pwrite;
            m_psel   <= 1'b1;
            state    <= SETUP;
          end
        end
        SETUP: begin
          m_penable <= 1'b1;
          to_cnt    <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            state     <= IDLE;
            if (to_fire && (timeout_cnt_o != 8'hFF))
              timeout_cnt_o <= timeout_cnt_o + 8'd1;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_periph_arbiter.sv
// Self-checking bench for apb_periph_arbiter: directed scenarios plus a randomized
// run against a transaction-level timing model.
module tb_apb_periph_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] s0_paddr, s0_pwdata, s0_prdata;
  logic        s0_pwrite, s0_psel, s0_penable, s0_pready, s0_pslverr;
  logic [31:0] s1_paddr, s1_pwdata, s1_prdata;
  logic        s1_pwrite, s1_psel, s1_penable, s1_pready, s1_pslverr;
  logic [31:0] m_paddr, m_pwdata, m_prdata;
  logic        m_pwrite, m_psel, m_penable, m_pready, m_pslverr;
  logic [7:0]  timeout_cnt_o;
  logic        busy_o;

  int tests_run = 0;
  int tests_failed = 0;

  apb_periph_arbiter #(
    .APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s0_paddr(s0_paddr), .s0_pwdata(s0_pwdata), .s0_pwrite(s0_pwrite), .s0_psel(s0_psel),
    .s0_penable(s0_penable), .s0_prdata(s0_prdata), .s0_pready(s0_pready), .s0_pslverr(s0_pslverr),
    .s1_paddr(s1_paddr), .s1_pwdata(s1_pwdata), .s1_pwrite(s1_pwrite), .s1_psel(s1_psel),
    .s1_penable(s1_penable), .s1_prdata(s1_prdata), .s1_pready(s1_pready), .s1_pslverr(s1_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite), .m_psel(m_psel),
    .m_penable(m_penable), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
    .timeout_cnt_o(timeout_cnt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic idle_inputs();
    s0_paddr = '0; s0_pwdata = '0; s0_pwrite = 1'b0; s0_psel = 1'b0; s0_penable = 1'b0;
    s1_paddr = '0; s1_pwdata = '0; s1_pwrite = 1'b0; s1_psel = 1'b0; s1_penable = 1'b0;
    m_prdata = '0; m_pready = 1'b0; m_pslverr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    tests_run++;
    if ({m_psel, m_penable, m_pwrite, busy_o} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b exp 0000", {m_psel, m_penable, m_pwrite, busy_o});
    end
    tests_run++;
    if ({m_paddr, m_pwdata} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_addr_data: got %h exp 0", {m_paddr, m_pwdata});
    end
    tests_run++;
    if (timeout_cnt_o !== 8'd0) begin
      tests_failed++; $display("FAIL reset_tcnt: got %0d exp 0", timeout_cnt_o);
    end
    rst_ni = 1'b1;
    tick();
    m_pready = 1'b1;
    #1;
    tests_run++;
    if ({busy_o, s0_pready, s1_pready} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_idle_ready: got %b exp 000", {busy_o, s0_pready, s1_pready});
    end
  endtask

  task automatic test_single_write();
    do_reset();
    tick();
    s0_psel = 1'b1; s0_pwrite = 1'b1; s0_paddr = 32'h1A10_4000; s0_pwdata = 32'hCAFE_F00D;
    m_pready = 1'b1; m_prdata = 32'h5555_AAAA;
    #1;
    tests_run++;
    if (m_psel !== 1'b0) begin
      tests_failed++; $display("FAIL single_t0_psel: got %b exp 0", m_psel);
    end
    tick(); #1;
    tests_run++;
    if ({m_psel, m_penable, s0_pready} !== 3'b100) begin
      tests_failed++; $display("FAIL single_setup: got %b exp 100", {m_psel, m_penable, s0_pready});
    end
    tests_run++;
    if ({m_paddr, m_pwdata, m_pwrite} !== {32'h1A10_4000, 32'hCAFE_F00D, 1'b1}) begin
      tests_failed++; $display("FAIL single_req: got %h %h %b", m_paddr, m_pwdata, m_pwrite);
    end
    tick(); s0_penable = 1'b1; #1;
    tests_run++;
    if ({m_psel, m_penable, s0_pready, s0_pslverr} !== 4'b1110) begin
      tests_failed++; $display("FAIL single_access: got %b exp 1110", {m_psel, m_penable, s0_pready, s0_pslverr});
    end
    tick(); s0_psel = 1'b0; s0_penable = 1'b0; #1;
    tests_run++;
    if ({busy_o, m_psel, m_penable} !== 3'b000 || m_paddr !== 32'h1A10_4000) begin
      tests_failed++; $display("FAIL single_idle_hold: got %b addr %h exp 000 addr 1a104000", {busy_o, m_psel, m_penable}, m_paddr);
    end
  endtask

  task automatic test_tie();
    int ord[$];
    do_reset();
    tick();
    s0_psel = 1'b1; s0_paddr = 32'h0000_0100; s0_pwdata = 32'h11;
    s1_psel = 1'b1; s1_paddr = 32'h0000_0200; s1_pwdata = 32'h22;
    m_pready = 1'b1; m_prdata = 32'hFEED_BEEF;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      #1;
      tests_run++;
      if ((s0_pready && s1_pready) || (!s0_pready && s0_prdata !== 32'h0) || (!s1_pready && s1_prdata !== 32'h0)) begin
        tests_failed++; $display("FAIL tie_loser_quiet: cyc %0d rdy %b%b data %h %h", i, s0_pready, s1_pready, s0_prdata, s1_prdata);
      end
      if (s0_pready) ord.push_back(0);
      if (s1_pready) ord.push_back(1);
    end
    tick(); s0_psel = 1'b0; s1_psel = 1'b0;
    tests_run++;
    if (ord.size() != 4) begin
      tests_failed++; $display("FAIL tie_count: got %0d exp 4", ord.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        tests_run++;
        if (ord[k] != (k % 2)) begin
          tests_failed++; $display("FAIL tie_order[%0d]: got s%0d exp s%0d", k, ord[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    int pulses = 0;
    tick();
    s1_psel = 1'b1; s1_pwrite = 1'b0; s1_paddr = 32'h4000_0ABC;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) tick();
      m_pready = (i == 7);
      m_prdata = (i == 7) ? 32'h1234_5678 : 32'hDEAD_0000 + 32'(i);
      #1;
      if (m_psel) begin
        tests_run++;
        if (m_paddr !== 32'h4000_0ABC) begin
          tests_failed++; $display("FAIL wait_addr_stable: cyc %0d got %h exp 40000abc", i, m_paddr);
        end
      end
      tests_run++;
      if (s1_pready !== (i == 7)) begin
        tests_failed++; $display("FAIL wait_pready: cyc %0d got %b exp %b", i, s1_pready, (i == 7));
      end
      if (s1_pready) begin
        pulses++;
        tests_run++;
        if (s1_prdata !== 32'h1234_5678 || s1_pslverr !== 1'b0) begin
          tests_failed++; $display("FAIL wait_data: got %h err %b exp 12345678 err 0", s1_prdata, s1_pslverr);
        end
      end
      if (i == 7) s1_psel = 1'b0;
    end
    tests_run++;
    if (pulses != 1) begin
      tests_failed++; $display("FAIL wait_pulses: got %0d exp 1", pulses);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    int cyc = 0;
    bit seen1 = 0;
    do_reset();
    m_pready = 1'b0; m_prdata = 32'hFFFF_FFFF; m_pslverr = 1'b0;
    while (pulses < 300 && cyc < 300 * 18 + 40) begin
      tick();
      if (cyc == 0) begin s0_psel = 1'b1; s0_paddr = 32'h2000_0000; end
      #1;
      if (pulses == 1 && !seen1) begin
        seen1 = 1;
        tests_run++;
        if (timeout_cnt_o !== 8'd1) begin
          tests_failed++; $display("FAIL timeout_cnt_first: got %0d exp 1", timeout_cnt_o);
        end
      end
      if (s0_pready) begin
        pulses++;
        if (pulses == 1) begin
          tests_run++;
          if (cyc != 17) begin
            tests_failed++; $display("FAIL timeout_latency: got cyc %0d exp 17", cyc);
          end
        end
        tests_run++;
        if (s0_pslverr !== 1'b1 || s0_prdata !== 32'h0) begin
          tests_failed++; $display("FAIL timeout_resp: got err %b data %h exp err 1 data 0", s0_pslverr, s0_prdata);
        end
      end
      cyc++;
    end
    tick(); s0_psel = 1'b0; #1;
    tests_run++;
    if (pulses != 300) begin
      tests_failed++; $display("FAIL timeout_budget: got %0d completions exp 300", pulses);
    end
    tests_run++;
    if (timeout_cnt_o !== 8'd255) begin
      tests_failed++; $display("FAIL timeout_saturate: got %0d exp 255", timeout_cnt_o);
    end
  endtask

  task automatic test_coincidence();
    do_reset();
    tick();
    s0_psel = 1'b1; s0_paddr = 32'h3000_0010;
    for (int i = 0; i < 19; i++) begin
      if (i > 0) tick();
      m_pready = (i == 17); m_pslverr = 1'b0;
      m_prdata = (i == 17) ? 32'h0BAD_F00D : 32'h0;
      #1;
      if (i == 17) begin
        tests_run++;
        if ({s0_pready, s0_pslverr} !== 2'b10 || s0_prdata !== 32'h0BAD_F00D) begin
          tests_failed++; $display("FAIL coinc_resp: got rdy %b err %b data %h exp 1 0 0badf00d", s0_pready, s0_pslverr, s0_prdata);
        end
        s0_psel = 1'b0;
      end
      if (i == 18) begin
        tests_run++;
        if (timeout_cnt_o !== 8'd0 || busy_o !== 1'b0) begin
          tests_failed++; $display("FAIL coinc_tcnt: got %0d busy %b exp 0 0", timeout_cnt_o, busy_o);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick();
    s1_psel = 1'b1; m_pready = 1'b1;
    repeat (3) tick();
    s1_psel = 1'b0; m_pready = 1'b0;
    tick();
    s0_psel = 1'b1;
    repeat (3) tick();
    m_pready = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    tests_run++;
    if ({m_psel, m_penable, busy_o, s0_pready} !== 4'b0000) begin
      tests_failed++; $display("FAIL rstmid_abort: got %b exp 0000", {m_psel, m_penable, busy_o, s0_pready});
    end
    tick();
    rst_ni = 1'b1; s0_psel = 1'b1; s1_psel = 1'b1; m_pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      tests_run++;
      if ({s0_pready, s1_pready} !== ((i == 2) ? 2'b10 : 2'b00)) begin
        tests_failed++; $display("FAIL rstmid_first_grant: cyc %0d got %b", i, {s0_pready, s1_pready});
      end
    end
    tick(); idle_inputs();
  endtask

  task automatic test_random();
    bit act[2];
    int gap[2];
    logic [31:0] ra[2], rd[2];
    bit rw[2];
    int free_at = 0, c0 = -100, comp = -100, waits = 0, who = 0, last = 1, n, tc_exp = 0;
    logic [31:0] cur_a = '0, cur_d = '0, ed;
    bit cur_w = 0, exp_sel, exp_en, done, timed, r0, r1, ee;
    do_reset();
    for (int r = 0; r < 2; r++) begin act[r] = 0; gap[r] = 0; end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      for (int r = 0; r < 2; r++) begin
        if (!act[r]) begin
          if (gap[r] > 0) gap[r]--;
          else if ($urandom_range(0, 2) != 0) begin
            act[r] = 1; ra[r] = $urandom; rd[r] = $urandom; rw[r] = 1'($urandom_range(0, 1));
          end
        end
      end
      s0_psel = act[0]; s0_paddr = ra[0]; s0_pwdata = rd[0]; s0_pwrite = rw[0];
      s1_psel = act[1]; s1_paddr = ra[1]; s1_pwdata = rd[1]; s1_pwrite = rw[1];
      if (cyc >= free_at && (act[0] || act[1])) begin
        who = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
        last = who; c0 = cyc;
        waits = ($urandom_range(0, 5) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 3);
        n = (waits + 1 > 16) ? 16 : waits + 1;
        comp = c0 + 1 + n; free_at = comp + 1;
        cur_a = ra[who]; cur_d = rd[who]; cur_w = rw[who];
      end
      if (cyc > c0 + 1 && cyc <= comp) m_pready = (cyc == c0 + 2 + waits);
      else m_pready = 1'($urandom_range(0, 1));
      m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
      #1;
      exp_sel = (cyc > c0 && cyc <= comp);
      exp_en = (cyc >= c0 + 2 && cyc <= comp);
      done = (cyc == comp);
      timed = (waits > 15);
      r0 = done && (who == 0); r1 = done && (who == 1);
      ed = timed ? 32'h0 : m_prdata;
      ee = timed ? 1'b1 : m_pslverr;
      tests_run++;
      if ({m_psel, m_penable, busy_o} !== {exp_sel, exp_en, exp_sel}) begin
        tests_failed++; $display("FAIL rnd_phase: cyc %0d got %b exp %b", cyc, {m_psel, m_penable, busy_o}, {exp_sel, exp_en, exp_sel});
      end
      if (exp_sel) begin
        tests_run++;
        if ({m_paddr, m_pwdata, m_pwrite} !== {cur_a, cur_d, cur_w}) begin
          tests_failed++; $display("FAIL rnd_req: cyc %0d got %h %h %b exp %h %h %b", cyc, m_paddr, m_pwdata, m_pwrite, cur_a, cur_d, cur_w);
        end
      end
      tests_run++;
      if ({s0_pready, s1_pready} !== {r0, r1}) begin
        tests_failed++; $display("FAIL rnd_pready: cyc %0d got %b exp %b", cyc, {s0_pready, s1_pready}, {r0, r1});
      end
      tests_run++;
      if (s0_prdata !== (r0 ? ed : 32'h0) || s0_pslverr !== (r0 && ee) ||
          s1_prdata !== (r1 ? ed : 32'h0) || s1_pslverr !== (r1 && ee)) begin
        tests_failed++; $display("FAIL rnd_resp: cyc %0d got %h/%b %h/%b", cyc, s0_prdata, s0_pslverr, s1_prdata, s1_pslverr);
      end
      tests_run++;
      if (timeout_cnt_o !== 8'(tc_exp)) begin
        tests_failed++; $display("FAIL rnd_tcnt: cyc %0d got %0d exp %0d", cyc, timeout_cnt_o, tc_exp);
      end
      if (done) begin
        if (timed && tc_exp < 255) tc_exp++;
        act[who] = 0;
        gap[who] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4);
      end
    end
    tick(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_tie();
    test_wait_states();
    test_timeout();
    test_coincidence();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apb_periph_arbiter.md
APB_PERIPH_ARBITER -- requirements
Module: apb_periph_arbiter

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 32, address width of all ports.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, data width of all ports.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 256, ACCESS-phase cycle limit; 0 disables the timeout.
REQ-004 SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst_ni  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports s0_paddr/s0_pwdata/s0_pwrite/s0_psel/s0_penable  in  ADDR/DATA/1/1/1  requester 0 APB request (core side).
REQ-007 SHALL have ports s0_prdata/s0_pready/s0_pslverr  out  DATA/1/1  requester 0 APB response.
REQ-008 SHALL have ports s1_* with the same set, widths and meaning as s0_*, for requester 1 (debug side).
REQ-009 SHALL have ports m_paddr/m_pwdata/m_pwrite/m_psel/m_penable  out  ADDR/DATA/1/1/1  shared peripheral-bus master request.
REQ-010 SHALL have ports m_prdata/m_pready/m_pslverr  in  DATA/1/1  shared peripheral-bus response.
REQ-011 SHALL have port timeout_cnt_o  out  8  saturating count of timed-out transfers.
REQ-012 SHALL have port busy_o  out  1  high whenever the FSM is not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SETUP, ACCESS.
REQ-014 IDLE: when any sX_psel=1, SHALL latch the winner's paddr/pwdata/pwrite, record the grant, and go to SETUP next cycle.
REQ-015 Arbitration SHALL be round-robin: with both psel=1 in IDLE, the requester not granted last wins; a sole requester always wins.
REQ-016 SETUP: m_psel=1, m_penable=0, latched request driven; SHALL go to ACCESS unconditionally.
REQ-017 ACCESS: m_psel=1, m_penable=1; on m_pready=1 SHALL go to IDLE.
REQ-018 All m_* request outputs SHALL be registered; in IDLE m_psel=0, m_penable=0, and m_paddr/m_pwdata/m_pwrite hold their last values.
REQ-019 Granted sX_pready SHALL be combinational: high only in ACCESS when m_pready=1 or the timeout fires; sX_prdata=m_prdata and sX_pslverr=m_pslverr in that cycle.
REQ-020 The non-granted requester SHALL see pready=0, pslverr=0, prdata=0 at all times.
REQ-021 Minimum latency SHALL be psel seen in IDLE at cycle t -> SETUP at t+1 -> ACCESS with pready at t+2 (3 cycles per transfer).
REQ-022 The timeout counter SHALL clear on entering ACCESS and increment each ACCESS cycle without m_pready.
REQ-023 When TIMEOUT_CYCLES>0 and the count reaches TIMEOUT_CYCLES-1 without m_pready, that cycle SHALL complete the transfer with sX_pready=1, sX_pslverr=1, sX_prdata=0, and go to IDLE.
REQ-024 m_pready and the timeout in the same cycle SHALL be treated as a normal slave completion: slave data and pslverr forwarded, timeout_cnt_o unchanged.
REQ-025 timeout_cnt_o SHALL increment by 1 per timeout and saturate at 255.
REQ-026 A requester deasserting psel mid-transfer SHALL NOT abort the transfer; it completes on the master side with the response discarded.
REQ-027 Back-to-back: a requester holding psel in the IDLE cycle after completion SHALL be re-arbitrated by REQ-015.

Reset
REQ-028 With rst_ni=0: state=IDLE, m_psel=0, m_penable=0, m_paddr=0, m_pwdata=0, m_pwrite=0, timeout counter=0, timeout_cnt_o=0, busy_o=0, last-grant=requester 1 (requester 0 wins first tie).
REQ-029 Reset asserted mid-transfer SHALL return to IDLE immediately; the in-flight transfer gets no pready.

Verification
REQ-030 Single write: s0 write 0x1A10_4000 data 0xCAFE_F00D, slave pready in first ACCESS -> m_psel at t+1, m_penable at t+2, s0_pready at t+2, pslverr=0.
REQ-031 Tie: s0 and s1 request together from reset, both held -> order s0, s1, s0, s1; the loser's pready stays 0.
REQ-032 Wait states: slave holds pready=0 for 5 ACCESS cycles, then returns 0x1234_5678 -> s1_prdata=0x1234_5678 with pready in that cycle only; m_paddr stable throughout.
REQ-033 Timeout: TIMEOUT_CYCLES=16, slave never ready -> s0_pready=1, pslverr=1, prdata=0 in the 16th ACCESS cycle; timeout_cnt_o=1; 300 timeouts -> 255.
REQ-034 Coincidence: m_pready=1 in the timeout cycle with pslverr=0 -> normal completion, timeout_cnt_o unchanged.
REQ-035 Reset mid-ACCESS -> m_psel=0 and busy_o=0 immediately; the next request is granted to s0 first.
